// File: rtl/noc_pkg.sv
// Shared NoC link definitions: packet layout, field widths/positions and the
// receive-controller state encoding.
package noc_pkg;

  localparam int PKT_W    = 35;
  localparam int ADDR_W   = 4;
  localparam int TYPE_W   = 2;
  localparam int DATA_W   = 25;
  localparam int DEST_LSB = 31;
  localparam int SRC_LSB  = 27;
  localparam int TYPE_LSB = 25;
  localparam int FIFO_W   = ADDR_W + TYPE_W + DATA_W;

  typedef enum logic [1:0] {
    IFMAP  = 2'b00,
    FILTER = 2'b01,
    PSUM   = 2'b10,
    SPIKE  = 2'b11
  } pkt_type_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src;
    pkt_type_t         ptype;
    logic [DATA_W-1:0] data;
  } noc_pkt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/depkt_fifo.sv
// First-word-fall-through FIFO for unpacked packets. The head output holds the
// last presented entry (or zero after reset) while the FIFO is empty.
module depkt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] hold_q, hold_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    head     = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
    hold_d   = head;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/depacketize_receive_controller.sv
// Receive endpoint of the NoC link: four-phase req/ack capture, destination
// check, FIFO buffering and valid/ready delivery. Define DEPKT_SYNC_EN to
// pass in_req through a 2-flop synchronizer.
module depacketize_receive_controller
  import noc_pkg::*;
#(
  parameter logic [3:0] NODE_ADDR = 4'd0,
  parameter int         DEPTH     = 4,
  parameter int         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_req,
  input  logic [PKT_W-1:0]  in_data,
  output logic              in_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_src,
  output logic [TYPE_W-1:0] out_type,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              addr_err
);

  rx_state_t         state_q, state_d;
  noc_pkt_t          pkt;
  logic              req_s;
  logic              capture, match, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] head;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

`ifdef DEPKT_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], in_req};
    req_s  = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end
`else
  assign req_s = in_req;
`endif

  always_comb begin
    pkt.dest  = in_data[DEST_LSB +: ADDR_W];
    pkt.src   = in_data[SRC_LSB +: ADDR_W];
    pkt.ptype = pkt_type_t'(in_data[TYPE_LSB +: TYPE_W]);
    pkt.data  = in_data[DATA_W-1:0];
  end

  // Misaddressed packets are acknowledged too so the link never stalls.
  always_comb begin
    capture   = (state_q == ST_IDLE) && req_s && !fifo_full;
    match     = (pkt.dest == NODE_ADDR);
    fifo_push = capture && match;
    fifo_pop  = !fifo_empty && out_ready;
    cnt_d     = fifo_push ? cnt_q + CNT_W'(1) : cnt_q;
    err_d     = err_q | (capture && !match);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_s && !fifo_full) state_d = ST_ACK;
      ST_ACK:  if (!req_s)              state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ack    = (state_q == ST_ACK);
    out_valid = !fifo_empty;
    out_data  = head[DATA_W-1:0];
    out_type  = head[DATA_W +: TYPE_W];
    out_src   = head[DATA_W+TYPE_W +: ADDR_W];
    pkt_cnt   = cnt_q;
    addr_err  = err_q;
  end

  depkt_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({pkt.src, pkt.ptype, pkt.data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule
